// File: rtl/stepper_cmd_pkg.sv
// Shared opcodes and readback constants for the stepper command engine.
package stepper_cmd_pkg;
  localparam logic [2:0] OP_SEL  = 3'd0;
  localparam logic [2:0] OP_DIR  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_ENA  = 3'd3;
  localparam logic [2:0] OP_RDH  = 3'd4;
  localparam logic [2:0] OP_CNT  = 3'd5;
  localparam logic [2:0] OP_STAT = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  localparam logic [15:0] TX_OK  = 16'h4F4B;
  localparam logic [15:0] TX_ERR = 16'hEEEE;

  localparam int CNT_W = 13;
endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: phase divider, 50% step toggle, signed position tracking.
// STEPPER_STEP_COUNT_EN adds a remaining-step counter that stops after the last full pulse.
module stepper_channel
  import stepper_cmd_pkg::*;
#(
  parameter int DIV_W = 13,
  parameter int POS_W = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [DIV_W-1:0] divider,
  input  logic             dir,
  input  logic             ena_wr,
  input  logic             ena_val,
  input  logic             zero,
  input  logic             cnt_ld,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             step,
  output logic [POS_W-1:0] pos,
  output logic             running
);
  logic [DIV_W-1:0] phase;
  logic             run_nxt, toggle, rise;

  assign toggle = running && (phase >= divider);
  assign rise   = toggle && !step && run_nxt;

`ifdef STEPPER_STEP_COUNT_EN
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             stop, stop_nxt;

  // stop marks that the final rising edge happened; the run ends on the next falling toggle
  always_comb begin
    run_nxt  = running;
    rem_nxt  = rem;
    stop_nxt = stop;
    if (ena_wr) begin
      run_nxt  = ena_val;
      rem_nxt  = '0;
      stop_nxt = 1'b0;
    end else if (cnt_ld) begin
      rem_nxt  = cnt_val;
      stop_nxt = 1'b0;
      if (cnt_val != '0) run_nxt = 1'b1;
    end else if (running && toggle) begin
      if (!step && rem != '0) begin
        rem_nxt = rem - 1'b1;
        if (rem == CNT_W'(1)) stop_nxt = 1'b1;
      end
      if (step && stop) begin
        run_nxt  = 1'b0;
        stop_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rem  <= '0;
      stop <= 1'b0;
    end else begin
      rem  <= rem_nxt;
      stop <= stop_nxt;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_ld, cnt_val};
  assign run_nxt    = ena_wr ? ena_val : running;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      phase   <= '0;
      step    <= 1'b0;
      pos     <= '0;
      running <= 1'b0;
    end else begin
      running <= run_nxt;
      if (!run_nxt) begin
        phase <= '0;
        step  <= 1'b0;
      end else if (toggle) begin
        phase <= '0;
        step  <= ~step;
      end else if (running) begin
        phase <= phase + 1'b1;
      end
      // zeroing beats a coincident rising edge
      if (zero)      pos <= '0;
      else if (rise) pos <= dir ? pos + 1'b1 : pos - 1'b1;
    end
  end
endmodule

// File: rtl/stepper_cmd_engine.sv
// SPI command decoder for NUM_CH stepper channels; returns a readback word for the next frame.
// Optional STEPPER_STEP_COUNT_EN enables opcode 5 (counted moves).
module stepper_cmd_engine
  import stepper_cmd_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int DIV_W  = 13,
  parameter int POS_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              word_rcvd,
  input  logic [15:0]       word_data,
  output logic [15:0]       tx_word,
  output logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] dir,
  output logic [NUM_CH-1:0] ena,
  output logic              cmd_err
);
  logic                              rcvd_q, acc, sel_ok, err_nxt;
  logic [3:0]                        sel, sel_nxt, wsel;
  logic [15:0]                       tx_nxt;
  logic [NUM_CH-1:0]                 zero, ena_wr, cnt_ld, dir_wr, div_wr, dir_r;
  logic [NUM_CH-1:0][DIV_W-1:0]      div_r;
  logic [NUM_CH-1:0][POS_W-1:0]      pos;
  logic signed [POS_W-1:0]           pos_cur;
  logic signed [31:0]                pos_ext;

  // rcvd_q tracks the line even in reset, so a word held across reset is never taken
  assign acc     = word_rcvd && !rcvd_q && !reset;
  assign wsel    = word_data[3:0];
  assign sel_ok  = int'(wsel) < NUM_CH;
  assign pos_cur = pos[sel];
  assign pos_ext = 32'(pos_cur);

  always_comb begin
    sel_nxt = sel;
    tx_nxt  = tx_word;
    err_nxt = 1'b0;
    zero    = '0;
    ena_wr  = '0;
    cnt_ld  = '0;
    dir_wr  = '0;
    div_wr  = '0;
    if (acc) begin
      tx_nxt = TX_OK;
      unique case (word_data[15:13])
        OP_SEL: begin
          if (sel_ok) begin
            sel_nxt    = wsel;
            zero[wsel] = word_data[4];
            tx_nxt     = word_data[4] ? 16'h0000 : pos[wsel][15:0];
          end else begin
            err_nxt = 1'b1;
            tx_nxt  = TX_ERR;
          end
        end
        OP_DIR:  dir_wr[sel] = 1'b1;
        OP_DIV:  div_wr[sel] = 1'b1;
        OP_ENA:  ena_wr[sel] = 1'b1;
        OP_RDH:  tx_nxt = pos_ext[31:16];
`ifdef STEPPER_STEP_COUNT_EN
        OP_CNT:  cnt_ld[sel] = 1'b1;
`endif
        OP_STAT: tx_nxt = 16'(ena);
        default: begin
          err_nxt = 1'b1;
          tx_nxt  = TX_ERR;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    rcvd_q <= word_rcvd;
    if (reset) begin
      sel     <= '0;
      tx_word <= 16'h0000;
      cmd_err <= 1'b0;
      dir_r   <= '0;
      div_r   <= '1;
    end else begin
      sel     <= sel_nxt;
      tx_word <= tx_nxt;
      cmd_err <= err_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (dir_wr[i]) dir_r[i] <= word_data[0];
        if (div_wr[i]) div_r[i] <= word_data[DIV_W-1:0];
      end
    end
  end

  assign dir = dir_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stepper_channel #(.DIV_W(DIV_W), .POS_W(POS_W)) u_ch (
      .CLK     (CLK),
      .reset   (reset),
      .divider (div_r[g]),
      .dir     (dir_r[g]),
      .ena_wr  (ena_wr[g]),
      .ena_val (word_data[0]),
      .zero    (zero[g]),
      .cnt_ld  (cnt_ld[g]),
      .cnt_val (word_data[CNT_W-1:0]),
      .step    (step[g]),
      .pos     (pos[g]),
      .running (ena[g])
    );
  end
endmodule
